// File: rtl/pipeline_pkg.sv
// Shared constants for the pipelined MIPS core: default address width,
// reset/exception vectors and the redirect channel numbering (lower index =
// older pipeline stage = higher priority).
package pipeline_pkg;

    localparam int          PIPE_ADDR_W     = 32;
    localparam int          PIPE_NUM_SRC    = 3;
    localparam logic [31:0] PIPE_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] PIPE_EXC_VECTOR = 32'h8000_0180;

    localparam int SRC_BRANCH = 0;
    localparam int SRC_JR     = 1;
    localparam int SRC_JUMP   = 2;

endpackage

// File: rtl/pc_redirect_arbiter.sv
// Fixed-priority pick over NUM_REQ redirect requesters. Each requester carries
// its own source index; the lowest index wins, and on equal indices the
// requester in the lower slot wins. Purely combinational so it can be reused
// by a wider fetch front end.
module pc_redirect_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2,
    parameter int ADDR_W  = 32
) (
    input  logic [NUM_REQ-1:0]        reqValid,
    input  logic [NUM_REQ*IDX_W-1:0]  reqIdx,
    input  logic [NUM_REQ*ADDR_W-1:0] reqAddr,
    output logic                      grantValid,
    output logic [IDX_W-1:0]          grantIdx,
    output logic [ADDR_W-1:0]         grantAddr
);

    logic              bestValid;
    logic [IDX_W-1:0]  bestIdx;
    logic [ADDR_W-1:0] bestAddr;

    // Scan slots in order; only a strictly lower index displaces the current
    // best, so earlier slots win ties.
    always_comb begin
        bestValid = 1'b0;
        bestIdx   = '0;
        bestAddr  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reqValid[i] && (!bestValid || (reqIdx[i*IDX_W +: IDX_W] < bestIdx))) begin
                bestValid = 1'b1;
                bestIdx   = reqIdx[i*IDX_W +: IDX_W];
                bestAddr  = reqAddr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign grantValid = bestValid;
    assign grantIdx   = bestIdx;
    assign grantAddr  = bestAddr;

endmodule

// File: rtl/pc_redirect_unit.sv
// Architectural PC register with redirect arbitration. Redirects that arrive
// while fetch is stalled are parked in a single pending entry and applied when
// the stall releases; exceptions bypass the stall entirely.
module pc_redirect_unit
    import pipeline_pkg::*;
#(
    parameter int                ADDR_W     = PIPE_ADDR_W,
    parameter int                NUM_SRC    = PIPE_NUM_SRC,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(PIPE_RESET_PC),
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(PIPE_EXC_VECTOR),
    parameter int                INC        = 4,
    parameter int                CNT_W      = 16
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      Stall,
    input  logic                      Exception,
    input  logic [NUM_SRC-1:0]        RedirValid,
    input  logic [NUM_SRC*ADDR_W-1:0] RedirAddr,
    output logic [ADDR_W-1:0]         PC,
    output logic [ADDR_W-1:0]         PCPlus,
    output logic                      Flush,
    output logic                      PendingValid,
    output logic                      AlignErr,
    output logic [CNT_W-1:0]          RedirCount
);

    localparam int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int NUM_REQ = NUM_SRC + 1;

    logic                      pendValid;
    logic [IDX_W-1:0]          pendIdx;
    logic [ADDR_W-1:0]         pendAddr;

    logic [NUM_REQ-1:0]        reqValid;
    logic [NUM_REQ*IDX_W-1:0]  reqIdx;
    logic [NUM_REQ*ADDR_W-1:0] reqAddr;

    logic                      candValid;
    logic [IDX_W-1:0]          candIdx;
    logic [ADDR_W-1:0]         candAddr;

    logic [ADDR_W-1:0]         nextPc;
    logic                      applied;
    logic                      alignBad;

    assign PCPlus       = PC + ADDR_W'(INC);
    assign PendingValid = pendValid;

    // New channels occupy the low slots so they beat the pending entry on an
    // index tie; the pending entry sits last with its remembered index.
    always_comb begin
        reqValid = {pendValid, RedirValid};
        reqAddr  = {pendAddr, RedirAddr};
        reqIdx   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            reqIdx[i*IDX_W +: IDX_W] = IDX_W'(i);
        end
        reqIdx[NUM_SRC*IDX_W +: IDX_W] = pendIdx;
    end

    pc_redirect_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W),
        .ADDR_W  (ADDR_W)
    ) u_arbiter (
        .reqValid   (reqValid),
        .reqIdx     (reqIdx),
        .reqAddr    (reqAddr),
        .grantValid (candValid),
        .grantIdx   (candIdx),
        .grantAddr  (candAddr)
    );

    // Next-PC select: exception, then redirect candidate, then sequential.
    always_comb begin
        nextPc   = PC;
        applied  = 1'b0;
        alignBad = 1'b0;
        if (Exception) begin
            nextPc  = EXC_VECTOR;
            applied = 1'b1;
        end else if (!Stall && candValid) begin
            nextPc   = {candAddr[ADDR_W-1:2], 2'b00};
            applied  = 1'b1;
            alignBad = |candAddr[1:0];
        end else if (!Stall) begin
            nextPc = PCPlus;
        end
    end

    // PC, status pulses and saturating redirect counter.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            PC         <= RESET_PC;
            Flush      <= 1'b0;
            AlignErr   <= 1'b0;
            RedirCount <= '0;
        end else begin
            PC       <= nextPc;
            Flush    <= applied;
            AlignErr <= alignBad;
            if (applied && (RedirCount != {CNT_W{1'b1}})) begin
                RedirCount <= RedirCount + CNT_W'(1);
            end
        end
    end

    // Pending entry: parked during a stall, dropped once anything is applied.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            pendValid <= 1'b0;
            pendIdx   <= '0;
            pendAddr  <= '0;
        end else if (Exception || !Stall) begin
            pendValid <= 1'b0;
            pendIdx   <= '0;
            pendAddr  <= '0;
        end else if (|RedirValid) begin
            pendValid <= 1'b1;
            pendIdx   <= candIdx;
            pendAddr  <= candAddr;
        end
    end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit: a table of per-cycle vectors with
// hand-derived expectations fed through a scoreboard queue, followed by
// hand-written sequences for wrap, mid-stall reset and counter saturation.
module tb_pc_redirect_unit;
    import pipeline_pkg::*;

    logic        Clk;
    logic        Rst;
    logic        Stall;
    logic        Exception;
    logic [2:0]  RedirValid;
    logic [95:0] RedirAddr;
    logic [31:0] PC;
    logic [31:0] PCPlus;
    logic        Flush;
    logic        PendingValid;
    logic        AlignErr;
    logic [15:0] RedirCount;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic        stall;
        logic        exc;
        logic [2:0]  valid;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] a2;
        logic [31:0] expPc;
        logic        expFlush;
        logic        expPend;
        logic        expAlign;
        logic [15:0] expCount;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic        flush;
        logic        pend;
        logic        align;
        logic [15:0] count;
    } exp_t;

    vec_t vecs[$];
    exp_t sbQueue[$];

    localparam logic [31:0] EXC = 32'h8000_0180;

    pc_redirect_unit dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Stall        (Stall),
        .Exception    (Exception),
        .RedirValid   (RedirValid),
        .RedirAddr    (RedirAddr),
        .PC           (PC),
        .PCPlus       (PCPlus),
        .Flush        (Flush),
        .PendingValid (PendingValid),
        .AlignErr     (AlignErr),
        .RedirCount   (RedirCount)
    );

    // Free-running clock, posedge at 5, 15, 25, ...
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Hard stop if the run somehow never reaches its summary.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(logic stall, logic exc, logic [2:0] valid,
                                   logic [31:0] a0, logic [31:0] a1, logic [31:0] a2,
                                   logic [31:0] expPc, logic expFlush, logic expPend,
                                   logic expAlign, logic [15:0] expCount);
        vec_t v;
        v.stall = stall; v.exc = exc; v.valid = valid;
        v.a0 = a0; v.a1 = a1; v.a2 = a2;
        v.expPc = expPc; v.expFlush = expFlush; v.expPend = expPend;
        v.expAlign = expAlign; v.expCount = expCount;
        return v;
    endfunction

    task automatic checkVal(string name, int id, logic [31:0] act, logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s (step %0d): got %h expected %h", name, id, act, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sbQueue.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL scoreboard: got empty queue expected entry");
        end else begin
            e = sbQueue.pop_front();
            checkVal("PC",           e.id, PC,                   e.pc);
            checkVal("PCPlus",       e.id, PCPlus,               e.pc + 32'd4);
            checkVal("Flush",        e.id, {31'd0, Flush},        {31'd0, e.flush});
            checkVal("PendingValid", e.id, {31'd0, PendingValid}, {31'd0, e.pend});
            checkVal("AlignErr",     e.id, {31'd0, AlignErr},     {31'd0, e.align});
            checkVal("RedirCount",   e.id, {16'd0, RedirCount},   {16'd0, e.count});
        end
    endtask

    task automatic applyStimulus(vec_t v, int id);
        exp_t e;
        @(negedge Clk);
        Stall      = v.stall;
        Exception  = v.exc;
        RedirValid = v.valid;
        RedirAddr  = {v.a2, v.a1, v.a0};
        e.id = id; e.pc = v.expPc; e.flush = v.expFlush; e.pend = v.expPend;
        e.align = v.expAlign; e.count = v.expCount;
        sbQueue.push_back(e);
        @(posedge Clk);
        #1;
        checkOutput();
    endtask

    initial begin
        Rst        = 1'b1;
        Stall      = 1'b0;
        Exception  = 1'b0;
        RedirValid = 3'b000;
        RedirAddr  = '0;

        // stall exc valid   a0(branch)    a1(jr)        a2(jump)      expPc         fl pend al count
        vecs.push_back(mkVec(0, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h4,        0, 0, 0, 16'd0));
        vecs.push_back(mkVec(0, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h8,        0, 0, 0, 16'd0));
        vecs.push_back(mkVec(0, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'hC,        0, 0, 0, 16'd0));
        vecs.push_back(mkVec(0, 0, 3'b111, 32'h40,       32'h100,      32'h200,      32'h40,       1, 0, 0, 16'd1));
        vecs.push_back(mkVec(0, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h44,       0, 0, 0, 16'd1));
        vecs.push_back(mkVec(1, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h44,       0, 0, 0, 16'd1));
        vecs.push_back(mkVec(1, 0, 3'b100, 32'h0,        32'h0,        32'h200,      32'h44,       0, 1, 0, 16'd1));
        vecs.push_back(mkVec(1, 0, 3'b001, 32'h80,       32'h0,        32'h0,        32'h44,       0, 1, 0, 16'd1));
        vecs.push_back(mkVec(1, 0, 3'b100, 32'h0,        32'h0,        32'h300,      32'h44,       0, 1, 0, 16'd1));
        vecs.push_back(mkVec(1, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h44,       0, 1, 0, 16'd1));
        vecs.push_back(mkVec(0, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h80,       1, 0, 0, 16'd2));
        vecs.push_back(mkVec(0, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h84,       0, 0, 0, 16'd2));
        vecs.push_back(mkVec(1, 0, 3'b010, 32'h0,        32'h104,      32'h0,        32'h84,       0, 1, 0, 16'd2));
        vecs.push_back(mkVec(1, 1, 3'b000, 32'h0,        32'h0,        32'h0,        EXC,          1, 0, 0, 16'd3));
        vecs.push_back(mkVec(0, 0, 3'b000, 32'h0,        32'h0,        32'h0,        EXC + 32'h4,  0, 0, 0, 16'd3));
        vecs.push_back(mkVec(0, 0, 3'b001, 32'h103,      32'h0,        32'h0,        32'h100,      1, 0, 1, 16'd4));
        vecs.push_back(mkVec(0, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h104,      0, 0, 0, 16'd4));
        vecs.push_back(mkVec(1, 0, 3'b010, 32'h0,        32'h20B,      32'h0,        32'h104,      0, 1, 0, 16'd4));
        vecs.push_back(mkVec(1, 0, 3'b010, 32'h0,        32'h300,      32'h0,        32'h104,      0, 1, 0, 16'd4));
        vecs.push_back(mkVec(0, 0, 3'b100, 32'h0,        32'h0,        32'h500,      32'h300,      1, 0, 0, 16'd5));
        vecs.push_back(mkVec(1, 0, 3'b010, 32'h0,        32'h700,      32'h0,        32'h300,      0, 1, 0, 16'd5));
        vecs.push_back(mkVec(0, 0, 3'b010, 32'h0,        32'h804,      32'h0,        32'h804,      1, 0, 0, 16'd6));
        vecs.push_back(mkVec(0, 0, 3'b010, 32'h0,        32'h804,      32'h0,        32'h804,      1, 0, 0, 16'd7));
        vecs.push_back(mkVec(0, 1, 3'b001, 32'h40,       32'h0,        32'h0,        EXC,          1, 0, 0, 16'd8));
        vecs.push_back(mkVec(1, 0, 3'b001, 32'h13,       32'h0,        32'h0,        EXC,          0, 1, 0, 16'd8));
        vecs.push_back(mkVec(0, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h10,       1, 0, 1, 16'd9));
        // Wrap of the sequential increment
        vecs.push_back(mkVec(0, 0, 3'b001, 32'hFFFF_FFFC, 32'h0,       32'h0,        32'hFFFF_FFFC, 1, 0, 0, 16'd10));
        vecs.push_back(mkVec(0, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 16'd10));
        vecs.push_back(mkVec(0, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h4,        0, 0, 0, 16'd10));
        // Park a branch so the following reset has something to discard
        vecs.push_back(mkVec(1, 0, 3'b001, 32'h80,       32'h0,        32'h0,        32'h4,        0, 1, 0, 16'd10));

        // Reset state while Rst is still asserted
        #13;
        checkVal("reset PC",         0, PC,                    32'h0);
        checkVal("reset PCPlus",     0, PCPlus,                32'h4);
        checkVal("reset Flush",      0, {31'd0, Flush},        32'd0);
        checkVal("reset Pending",    0, {31'd0, PendingValid}, 32'd0);
        checkVal("reset AlignErr",   0, {31'd0, AlignErr},     32'd0);
        checkVal("reset RedirCount", 0, {16'd0, RedirCount},   32'd0);
        #3;
        Rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i + 1);
        end

        // Asynchronous reset in the middle of a stalled cycle with a pending entry
        #2;
        Stall      = 1'b0;
        RedirValid = 3'b000;
        Rst        = 1'b1;
        #1;
        checkVal("midstall reset PC",      100, PC,                    32'h0);
        checkVal("midstall reset Pending", 100, {31'd0, PendingValid}, 32'd0);
        checkVal("midstall reset Count",   100, {16'd0, RedirCount},   32'd0);
        Rst = 1'b0;
        applyStimulus(mkVec(0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h4, 0, 0, 0, 16'd0), 101);

        // Back-to-back branches until the counter saturates
        @(negedge Clk);
        Stall      = 1'b0;
        Exception  = 1'b0;
        RedirValid = 3'b001;
        RedirAddr  = {32'h0, 32'h0, 32'h40};
        repeat (65534) @(posedge Clk);
        #1;
        checkVal("count before saturation", 200, {16'd0, RedirCount}, 32'h0000_FFFE);
        repeat (5) @(posedge Clk);
        #1;
        checkVal("count saturated", 201, {16'd0, RedirCount}, 32'h0000_FFFF);
        applyStimulus(mkVec(0, 0, 3'b001, 32'h40, 32'h0, 32'h0, 32'h40, 1, 0, 0, 16'hFFFF), 202);
        applyStimulus(mkVec(0, 0, 3'b000, 32'h0,  32'h0, 32'h0, 32'h44, 0, 0, 0, 16'hFFFF), 203);

        checkVal("scoreboard drained", 300, sbQueue.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
